bon_hit_logger: RTL

BON_HIT_LOGGER -- requirements
Module: bon_hit_logger

---
 rtl/bon_hit_logger.sv | 115 +++++++++++
 1 files changed

// File: rtl/bon_hit_logger.sv
// Passive tap on a BON search engine: logs hit addresses during a run into a
// small circular buffer, then drains them in arrival order once BON finishes.
module bon_hit_logger #(
    parameter int ADDR_W = 10,
    parameter int RES_W  = 10,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flag,
    input  logic              fin,
    input  logic [RES_W-1:0]  result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W:0]   hit_count,
    output logic              overflow,
    output logic [RES_W-1:0]  final_result,
    output logic              done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, LOG, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              empty, full;
    logic              hit, arm, pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Pointers carry one extra wrap bit so equal indices can mean full or empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hit       = 1'b0;
        arm       = 1'b0;
        pop       = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOG;
                    arm       = 1'b1;
                end
            end
            LOG: begin
                hit = en & flag;
                if (fin) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = !empty;
                pop       = !empty && out_ready;
                if (empty) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = LOG;
                    arm       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Head is read straight from stored state, so nothing from the inputs reaches it.
    assign out_addr = out_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            hit_count    <= '0;
            overflow     <= 1'b0;
            final_result <= '0;
        end else begin
            if (arm) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                hit_count <= '0;
                overflow  <= 1'b0;
            end
            if (hit) begin
                hit_count <= sat_inc(hit_count);
                if (full) overflow <= 1'b1;
                else      wr_ptr   <= wr_ptr + (PTR_W+1)'(1);
            end
            if (state == LOG && fin) final_result <= result;
            if (pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (hit && !full) mem[wr_ptr[PTR_W-1:0]] <= addr;
    end

endmodule
